fixed_inner_product_pipe: RTL and testbench

- Pipelined, handshaked inner-product engine for the LSTM datapath.
- Consumes pairs of sign-magnitude fixed-point operands (1 sign, 1 integer, FRAC_BITS fraction), one pair per cycle.
- Accumulates VEC_LEN products in an internal two's-complement accumulator.
- Emits one saturated sign-magnitude result per vector over a valid/ready output handshake.
- Sits between the weight/activation streams and the gate nonlinearity stage; supersedes the bare combinational product unit.

---
 rtl/fixed_pkg.sv | 24 ++
 rtl/fixed_sm_mul_stage.sv | 74 +++++++
 rtl/fixed_inner_product_pipe.sv | 134 +++++++++++++
 tb/tb_fixed_inner_product_pipe.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared Q-format constants, sign-magnitude field helpers and FSM encoding
// for the fixed-point inner-product datapath.
package fixed_pkg;

  localparam int DEF_BIT_WIDTH = 8;
  localparam int DEF_FRAC_BITS = 6;
  localparam int DEF_OUT_WIDTH = 8;

  // Sign-magnitude layout: sign in the MSB, magnitude in the bits below it.
  function automatic int sm_sign_pos(input int width);
    return width - 1;
  endfunction

  function automatic int sm_mag_width(input int width);
    return width - 1;
  endfunction

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } ip_state_e;

endpackage

// File: rtl/fixed_sm_mul_stage.sv
// Two-stage registered sign-magnitude multiplier: stage 1 captures the
// operands, stage 2 holds the product sign/magnitude with a matching valid pipe.
module fixed_sm_mul_stage
  import fixed_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
  input  logic                         iClk,
  input  logic                         iReset,
  input  logic                         iValid,
  input  logic [BIT_WIDTH-1:0]         iMul1,
  input  logic [BIT_WIDTH-1:0]         iMul2,
  output logic                         oSign,
  output logic [2*(BIT_WIDTH-1)-1:0]   oMag,
  output logic                         oValid,
  output logic                         oBusy
);

  localparam int SIGN_POS = sm_sign_pos(BIT_WIDTH);
  localparam int MAG_W    = sm_mag_width(BIT_WIDTH);
  localparam int PROD_W   = 2 * MAG_W;

  logic [BIT_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                 s1_valid_q, s1_valid_d;
  logic                 p_sign_q, p_sign_d;
  logic [PROD_W-1:0]    p_mag_q, p_mag_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [PROD_W-1:0]    mag_prod;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    p_sign_d   = p_sign_q;
    p_mag_d    = p_mag_q;
    s1_valid_d = iValid;
    s2_valid_d = s1_valid_q;
    mag_prod   = PROD_W'(a_q[MAG_W-1:0]) * PROD_W'(b_q[MAG_W-1:0]);
    if (iValid) begin
      a_d = iMul1;
      b_d = iMul2;
    end
    // A zero magnitude is forced to +0 so negative zero never reaches the accumulator.
    if (s1_valid_q) begin
      p_mag_d  = mag_prod;
      p_sign_d = (a_q[SIGN_POS] ^ b_q[SIGN_POS]) && (mag_prod != '0);
    end
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // NOTE: datapath registers are not reset; the valid pipe alone decides when they matter.
  always_ff @(posedge iClk) begin
    a_q      <= a_d;
    b_q      <= b_d;
    p_sign_q <= p_sign_d;
    p_mag_q  <= p_mag_d;
  end

  assign oSign  = p_sign_q;
  assign oMag   = p_mag_q;
  assign oValid = s2_valid_q;
  assign oBusy  = s1_valid_q | s2_valid_q;

endmodule

// File: rtl/fixed_inner_product_pipe.sv
// Handshaked inner-product engine: accumulates VEC_LEN sign-magnitude products
// and emits one saturated sign-magnitude result per vector.
module fixed_inner_product_pipe
  import fixed_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int VEC_LEN   = 16,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                 iClk,
  input  logic                 iReset,
  input  logic                 iValid,
  output logic                 oReady,
  input  logic [BIT_WIDTH-1:0] iMul1,
  input  logic [BIT_WIDTH-1:0] iMul2,
  output logic                 oValid,
  input  logic                 iReady,
  output logic [OUT_WIDTH-1:0] oResult,
  output logic                 oSat
);

  localparam int PROD_W = 2 * (BIT_WIDTH - 1);
  localparam int CNT_W  = $clog2(VEC_LEN);
  localparam int ACC_W  = PROD_W + CNT_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);
  localparam logic [ACC_W-1:0] RES_MAX  = ACC_W'((1 << (OUT_WIDTH - 1)) - 1);

  ip_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [OUT_WIDTH-1:0] res_q, res_d;
  logic                 sat_q, sat_d;

  logic                 ready;
  logic                 accept;
  logic                 prod_sign;
  logic [PROD_W-1:0]    prod_mag;
  logic                 prod_valid;
  logic                 mul_busy;
  logic [ACC_W-1:0]     prod_ext;
  logic                 acc_neg;
  logic [ACC_W-1:0]     acc_abs;
  logic [ACC_W-1:0]     mag_full;
  logic [OUT_WIDTH-2:0] mag_out;
  logic                 mag_sat;

  assign ready  = (state_q == ACCUM) && !iReset;
  assign accept = iValid && ready;

  fixed_sm_mul_stage #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_mul (
    .iClk   (iClk),
    .iReset (iReset),
    .iValid (accept),
    .iMul1  (iMul1),
    .iMul2  (iMul2),
    .oSign  (prod_sign),
    .oMag   (prod_mag),
    .oValid (prod_valid),
    .oBusy  (mul_busy)
  );

  // Result formatting: truncate |acc| toward zero, clamp, and never emit -0.
  always_comb begin
    prod_ext = ACC_W'(prod_mag);
    if (prod_sign) prod_ext = -prod_ext;
    acc_neg  = acc_q[ACC_W-1];
    acc_abs  = acc_neg ? -acc_q : acc_q;
    mag_full = acc_abs >> FRAC_BITS;
    mag_sat  = mag_full > RES_MAX;
    mag_out  = mag_sat ? RES_MAX[OUT_WIDTH-2:0] : mag_full[OUT_WIDTH-2:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    sat_d   = sat_q;
    if (prod_valid) acc_d = acc_q + prod_ext;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      // Leave only once the last product has landed in the accumulator.
      DRAIN: begin
        if (!mul_busy) begin
          state_d = OUT;
          res_d   = {acc_neg && (mag_out != '0), mag_out};
          sat_d   = mag_sat;
        end
      end
      OUT: begin
        if (iReady) begin
          state_d = ACCUM;
          acc_d   = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
    end
  end

  assign oReady  = ready;
  assign oValid  = (state_q == OUT);
  assign oResult = res_q;
  assign oSat    = sat_q;

endmodule

// File: tb/tb_fixed_inner_product_pipe.sv
// Directed, table-driven bench for fixed_inner_product_pipe with VEC_LEN=4.
module tb_fixed_inner_product_pipe;

  logic       iClk = 1'b0;
  logic       iReset;
  logic       iValid;
  logic       oReady;
  logic [7:0] iMul1;
  logic [7:0] iMul2;
  logic       oValid;
  logic       iReady;
  logic [7:0] oResult;
  logic       oSat;

  int checks = 0;
  int errors = 0;

  always #5 iClk = ~iClk;

  fixed_inner_product_pipe #(
    .BIT_WIDTH (8),
    .FRAC_BITS (6),
    .VEC_LEN   (4),
    .OUT_WIDTH (8)
  ) dut (
    .iClk    (iClk),
    .iReset  (iReset),
    .iValid  (iValid),
    .oReady  (oReady),
    .iMul1   (iMul1),
    .iMul2   (iMul2),
    .oValid  (oValid),
    .iReady  (iReady),
    .oResult (oResult),
    .oSat    (oSat)
  );

  typedef struct packed {
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [7:0]      exp_res;
    logic            exp_sat;
    logic            hold;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Feeds one vector, checks drain latency, result, optional backpressure and handshake.
  task automatic run_vector(input vec_t v, input int idx);
    int guard;
    int lat;
    iReady = v.hold ? 1'b0 : 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      iValid = 1'b1;
      iMul1  = v.a[i];
      iMul2  = v.b[i];
      guard  = 0;
      while (!oReady && guard < 20) begin
        @(negedge iClk);
        guard++;
      end
      if (guard >= 20) check($sformatf("v%0d accept_timeout", idx), 32'(guard), 32'd0);
    end
    @(negedge iClk);
    iValid = 1'b0;
    check($sformatf("v%0d drain_ready", idx), 32'(oReady), 32'd0);
    lat = 1;
    while (!oValid && lat < 30) begin
      @(negedge iClk);
      lat++;
    end
    check($sformatf("v%0d latency", idx), 32'(lat), 32'd4);
    check($sformatf("v%0d result", idx), 32'(oResult), 32'(v.exp_res));
    check($sformatf("v%0d sat", idx), 32'(oSat), 32'(v.exp_sat));
    if (v.hold) begin
      for (int c = 0; c < 5; c++) begin
        iValid = 1'b1;
        iMul1  = 8'h7F;
        iMul2  = 8'h7F;
        @(negedge iClk);
        check($sformatf("v%0d hold%0d valid", idx, c), 32'(oValid), 32'd1);
        check($sformatf("v%0d hold%0d result", idx, c), 32'(oResult), 32'(v.exp_res));
        check($sformatf("v%0d hold%0d sat", idx, c), 32'(oSat), 32'(v.exp_sat));
        check($sformatf("v%0d hold%0d ready", idx, c), 32'(oReady), 32'd0);
      end
      iValid = 1'b0;
      iReady = 1'b1;
    end
    @(negedge iClk);
    check($sformatf("v%0d post_valid", idx), 32'(oValid), 32'd0);
    check($sformatf("v%0d post_ready", idx), 32'(oReady), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t rv;
    //           a (elem 3..0)                b (elem 3..0)                res    sat   hold
    vecs[0] = '{a: {8'h20, 8'h20, 8'h20, 8'h20}, b: {8'h20, 8'h20, 8'h20, 8'h20}, exp_res: 8'h40, exp_sat: 1'b0, hold: 1'b0};
    vecs[1] = '{a: {8'h80, 8'h20, 8'hC0, 8'h40}, b: {8'h40, 8'h20, 8'h40, 8'h40}, exp_res: 8'h10, exp_sat: 1'b0, hold: 1'b0};
    vecs[2] = '{a: {8'hC0, 8'hC0, 8'hC0, 8'hC0}, b: {8'h40, 8'h40, 8'h40, 8'h40}, exp_res: 8'hFF, exp_sat: 1'b1, hold: 1'b0};
    vecs[3] = '{a: {8'h40, 8'h40, 8'h40, 8'h40}, b: {8'h40, 8'h40, 8'h40, 8'h40}, exp_res: 8'h7F, exp_sat: 1'b1, hold: 1'b0};
    vecs[4] = '{a: {8'h00, 8'h01, 8'h20, 8'h20}, b: {8'h7F, 8'h01, 8'h20, 8'hA0}, exp_res: 8'h00, exp_sat: 1'b0, hold: 1'b0};
    vecs[5] = '{a: {8'h80, 8'h20, 8'hC0, 8'h40}, b: {8'h40, 8'h20, 8'h40, 8'h40}, exp_res: 8'h10, exp_sat: 1'b0, hold: 1'b1};
    vecs[6] = '{a: {8'h20, 8'h20, 8'h20, 8'h20}, b: {8'h20, 8'h20, 8'h20, 8'h20}, exp_res: 8'h40, exp_sat: 1'b0, hold: 1'b0};

    iReset = 1'b1;
    iValid = 1'b0;
    iReady = 1'b1;
    iMul1  = '0;
    iMul2  = '0;
    repeat (2) @(negedge iClk);
    check("reset ready", 32'(oReady), 32'd0);
    check("reset valid", 32'(oValid), 32'd0);
    check("reset result", 32'(oResult), 32'd0);
    check("reset sat", 32'(oSat), 32'd0);
    iReset = 1'b0;
    @(negedge iClk);
    check("post_reset ready", 32'(oReady), 32'd1);

    for (int k = 0; k < 7; k++) run_vector(vecs[k], k);

    // Reset after two accepts of the largest product must leave no residue.
    for (int i = 0; i < 2; i++) begin
      iValid = 1'b1;
      iMul1  = 8'h7F;
      iMul2  = 8'h7F;
      @(negedge iClk);
    end
    iValid = 1'b0;
    iReset = 1'b1;
    #1;
    check("midreset ready_low", 32'(oReady), 32'd0);
    @(negedge iClk);
    iReset = 1'b0;
    check("midreset valid", 32'(oValid), 32'd0);
    check("midreset result", 32'(oResult), 32'd0);
    #1;
    check("midreset ready", 32'(oReady), 32'd1);
    rv = vecs[0];
    run_vector(rv, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
